// File: rtl/mipi_csi_rx_pkg.sv
// Shared types and helpers for the CSI-2 receive lane aligner.
package mipi_csi_rx_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    STREAM = 2'd2,
    ERROR  = 2'd3
  } aligner_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } lane_byte_t;

  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [2:0] active_lanes);
    case (active_lanes)
      3'd4:    lane_mask = 4'b1111;
      3'd2:    lane_mask = 4'b1100;
      3'd1:    lane_mask = 4'b1000;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mipi_csi_rx_lane_delay_line.sv
// Per-lane {valid, byte} shift register of depth MAX_SKEW+1 with a
// registered tap select that is loaded once per packet.
module mipi_csi_rx_lane_delay_line
  import mipi_csi_rx_pkg::*;
#(
  parameter int MAX_SKEW = 3,
  localparam int DW = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          shift_en_i,
  input  lane_byte_t    din_i,
  input  logic          tap_load_i,
  input  logic [DW-1:0] tap_sel_i,
  output lane_byte_t    tap_o
);

  lane_byte_t    r_sr [MAX_SKEW+1];
  logic [DW-1:0] r_tap;

  // Shift every cycle; a lane outside the mask feeds zeros.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i <= MAX_SKEW; i++) r_sr[i] <= '0;
      r_tap <= '0;
    end else begin
      r_sr[0] <= shift_en_i ? din_i : '0;
      for (int i = 1; i <= MAX_SKEW; i++) r_sr[i] <= r_sr[i-1];
      if (tap_load_i) r_tap <= tap_sel_i;
    end
  end

  assign tap_o = r_sr[r_tap];

endmodule

// File: rtl/mipi_csi_rx_lane_aligner.sv
// Deskews up to MAX_SKEW byte clocks between active CSI-2 lanes so the first
// payload byte of every lane reaches the protocol layer on the same cycle.
module mipi_csi_rx_lane_aligner
  import mipi_csi_rx_pkg::*;
#(
  parameter int MAX_SKEW = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [2:0]  active_lanes_i,
  input  logic [3:0]  data_valid_i,
  input  logic [31:0] data_i,
  output logic [3:0]  data_valid_o,
  output logic [31:0] data_o,
  output logic        err_skew_o,
  output logic        aligned_o
);

  localparam int DW = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1;

  aligner_state_t r_state;
  logic [3:0]     r_mask;
  logic [3:0]     r_arrived;
  logic           r_armed;
  logic [DW-1:0]  r_skew_cnt;
  logic [DW-1:0]  r_off [NUM_LANES];

  logic [3:0]     w_mask_in;
  logic [3:0]     w_mask;
  logic [3:0]     w_vld;
  logic [3:0]     w_new;
  logic [3:0]     w_arrived_nxt;
  logic [3:0]     w_tap_vld;
  logic           w_go_stream;
  logic [DW-1:0]  w_off_nxt [NUM_LANES];
  logic [DW-1:0]  w_delay [NUM_LANES];
  logic [DW-1:0]  w_max_off;
  lane_byte_t     w_din [NUM_LANES];
  lane_byte_t     w_tap [NUM_LANES];

  // Outside IDLE the configuration latched at packet start is authoritative.
  assign w_mask_in     = lane_mask(active_lanes_i);
  assign w_mask        = (r_state == IDLE) ? w_mask_in : r_mask;
  assign w_vld         = data_valid_i & w_mask;
  assign w_new         = (r_state == IDLE) ? w_vld : (w_vld & ~r_arrived);
  assign w_arrived_nxt = (r_state == IDLE) ? w_vld : (r_arrived | w_vld);
  assign w_go_stream   = ((r_state == IDLE) && r_armed && (w_vld != 4'b0000) && (w_vld == w_mask))
                      || ((r_state == ALIGN) && (w_arrived_nxt == r_mask));

  // Arrival offsets including this cycle's newcomers, and the resulting tap delays.
  always_comb begin
    w_max_off = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (r_state == IDLE) begin
        w_off_nxt[l] = '0;
      end else if (w_new[l]) begin
        w_off_nxt[l] = r_skew_cnt + DW'(1);
      end else begin
        w_off_nxt[l] = r_off[l];
      end
      w_max_off = (w_mask[l] && (w_off_nxt[l] > w_max_off)) ? w_off_nxt[l] : w_max_off;
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      w_delay[l] = w_max_off - w_off_nxt[l];
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign w_din[l]     = '{valid: data_valid_i[l], data: data_i[8*l +: 8]};
    assign w_tap_vld[l] = w_tap[l].valid & r_mask[l];

    mipi_csi_rx_lane_delay_line #(
      .MAX_SKEW(MAX_SKEW)
    ) u_delay_line (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .shift_en_i (w_mask[l]),
      .din_i      (w_din[l]),
      .tap_load_i (w_go_stream),
      .tap_sel_i  (w_delay[l]),
      .tap_o      (w_tap[l])
    );
  end

  // Alignment state machine with registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_mask       <= 4'b0000;
      r_arrived    <= 4'b0000;
      r_armed      <= 1'b0;
      r_skew_cnt   <= '0;
      for (int l = 0; l < NUM_LANES; l++) r_off[l] <= '0;
      data_valid_o <= 4'b0000;
      data_o       <= 32'h0000_0000;
      err_skew_o   <= 1'b0;
      aligned_o    <= 1'b0;
    end else begin
      data_valid_o <= 4'b0000;
      data_o       <= 32'h0000_0000;
      err_skew_o   <= 1'b0;
      aligned_o    <= 1'b0;
      case (r_state)
        IDLE: begin
          // A stream already in flight at reset release is never picked up mid-packet.
          if (!r_armed) begin
            if (w_vld == 4'b0000) r_armed <= 1'b1;
          end else if (w_vld != 4'b0000) begin
            r_mask     <= w_mask_in;
            r_arrived  <= w_vld;
            r_skew_cnt <= '0;
            for (int l = 0; l < NUM_LANES; l++) r_off[l] <= w_off_nxt[l];
            if (w_go_stream) begin
              r_state   <= STREAM;
              aligned_o <= 1'b1;
            end else begin
              r_state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          r_skew_cnt <= r_skew_cnt + DW'(1);
          r_arrived  <= w_arrived_nxt;
          for (int l = 0; l < NUM_LANES; l++) r_off[l] <= w_off_nxt[l];
          if (w_go_stream) begin
            r_state   <= STREAM;
            aligned_o <= 1'b1;
          end else if ((int'(r_skew_cnt) + 1) >= MAX_SKEW) begin
            r_state    <= ERROR;
            err_skew_o <= 1'b1;
          end
        end
        STREAM: begin
          data_valid_o <= w_tap_vld;
          for (int l = 0; l < NUM_LANES; l++) begin
            data_o[8*l +: 8] <= w_tap_vld[l] ? w_tap[l].data : 8'h00;
          end
          if ((w_tap_vld == 4'b0000) && (w_vld == 4'b0000)) begin
            r_state <= IDLE;
          end else begin
            aligned_o <= 1'b1;
          end
        end
        ERROR: begin
          if (w_vld == 4'b0000) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_csi_rx_lane_aligner.sv
// Scoreboard bench for the lane aligner: each window plans stimulus and the
// expected per-cycle outputs, pushes expectations as it drives, and a monitor pops and compares.
module tb_mipi_csi_rx_lane_aligner;

  localparam int MAX_SKEW = 3;
  localparam int W        = 40;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [2:0]  active_lanes_i;
  logic [3:0]  data_valid_i;
  logic [31:0] data_i;
  logic [3:0]  data_valid_o;
  logic [31:0] data_o;
  logic        err_skew_o;
  logic        aligned_o;

  always #5 clk = ~clk;

  mipi_csi_rx_lane_aligner #(.MAX_SKEW(MAX_SKEW)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .active_lanes_i (active_lanes_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .data_valid_o   (data_valid_o),
    .data_o         (data_o),
    .err_skew_o     (err_skew_o),
    .aligned_o      (aligned_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          win;
    int          cyc;
    logic [3:0]  dv;
    logic [31:0] d;
    logic        err;
    logic        al;
  } exp_t;

  exp_t sb_q[$];

  logic [3:0]  st_v  [W];
  logic [31:0] st_d  [W];
  logic        st_rst[W];
  logic [3:0]  ex_v  [W];
  logic [31:0] ex_d  [W];
  logic        ex_e  [W];
  logic        ex_a  [W];

  function automatic logic [7:0] pb(input int id, input int l, input int k);
    logic [31:0] hdr;
    hdr = 32'h0105_003E;
    if (k == 0 && id <= 2) pb = hdr[8*l +: 8];
    else                   pb = 8'((id * 37 + l * 16 + k * 5 + 1) % 256);
  endfunction

  task automatic clear_window();
    for (int c = 0; c < W; c++) begin
      st_v[c] = 4'b0000; st_d[c] = 32'h0; st_rst[c] = 1'b0;
      ex_v[c] = 4'b0000; ex_d[c] = 32'h0; ex_e[c] = 1'b0; ex_a[c] = 1'b0;
    end
  endtask

  // Plan one packet on the lanes in act; expectation follows the deskew rules.
  task automatic plan_packet(input int id, input logic [3:0] act,
                             input int s0, input int s1, input int s2, input int s3, input int len);
    int s[4];
    int n, mn, e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    n = -1; mn = 1000;
    for (int l = 0; l < 4; l++) begin
      if (act[l]) begin
        for (int k = 0; k < len; k++) begin
          st_v[s[l]+k][l]         = 1'b1;
          st_d[s[l]+k][8*l +: 8]  = pb(id, l, k);
        end
        if (s[l] > n)  n  = s[l];
        if (s[l] < mn) mn = s[l];
      end
    end
    if (n - mn > MAX_SKEW) begin
      ex_e[mn + MAX_SKEW + 1] = 1'b1;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (act[l]) begin
          for (int k = 0; k < len; k++) begin
            ex_v[n+2+k][l]        = 1'b1;
            ex_d[n+2+k][8*l +: 8] = pb(id, l, k);
          end
        end
      end
      e = n + 1;
      while (e + 1 < W && (((ex_v[e+1] & act) != 4'b0000) || ((st_v[e] & act) != 4'b0000))) e++;
      for (int c = n + 1; c <= e; c++) ex_a[c] = 1'b1;
    end
  endtask

  task automatic run_window(input int win, input logic [2:0] lanes);
    exp_t x;
    active_lanes_i = lanes;
    for (int c = 0; c < W; c++) begin
      @(posedge clk);
      #1;
      reset_i      = st_rst[c];
      data_valid_i = st_v[c];
      data_i       = st_d[c];
      x.win = win; x.cyc = c;
      x.dv = ex_v[c]; x.d = ex_d[c]; x.err = ex_e[c]; x.al = ex_a[c];
      sb_q.push_back(x);
    end
  endtask

  // Output monitor: compares each cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check_val($sformatf("w%0d c%0d valid", x.win, x.cyc), {28'h0, data_valid_o}, {28'h0, x.dv});
      check_val($sformatf("w%0d c%0d data", x.win, x.cyc), data_o, x.d);
      check_val($sformatf("w%0d c%0d err", x.win, x.cyc), {31'h0, err_skew_o}, {31'h0, x.err});
      check_val($sformatf("w%0d c%0d aligned", x.win, x.cyc), {31'h0, aligned_o}, {31'h0, x.al});
    end
  end

  initial begin
    reset_i        = 1'b1;
    active_lanes_i = 3'd4;
    data_valid_i   = 4'b0000;
    data_i         = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset valid",   {28'h0, data_valid_o}, 32'h0);
    check_val("reset data",    data_o, 32'h0);
    check_val("reset err",     {31'h0, err_skew_o}, 32'h0);
    check_val("reset aligned", {31'h0, aligned_o}, 32'h0);

    // 4 lanes, all start together
    clear_window();
    plan_packet(1, 4'b1111, 3, 3, 3, 3, 8);
    run_window(1, 3'd4);

    // 4 lanes skewed: lane0 T, lane1 T+1, lane2 T+3, lane3 T+2
    clear_window();
    plan_packet(2, 4'b1111, 3, 4, 6, 5, 8);
    run_window(2, 3'd4);

    // 2 lanes with garbage valid on lanes 0/1
    clear_window();
    for (int c = 2; c < 12; c++) begin
      st_v[c][1:0]  = 2'b11;
      st_d[c][15:0] = 16'(16'hA55A + c);
    end
    plan_packet(3, 4'b1100, 0, 0, 3, 4, 8);
    run_window(3, 3'd2);

    // skew of 4 on lane 1 times out, then a clean packet
    clear_window();
    plan_packet(4, 4'b1111, 3, 7, 3, 3, 6);
    plan_packet(5, 4'b1111, 16, 16, 16, 16, 6);
    run_window(4, 3'd4);

    // 1 lane, 11-byte packet on lane 3
    clear_window();
    plan_packet(6, 4'b1000, 0, 0, 0, 3, 11);
    run_window(5, 3'd1);

    // reset pulse mid-stream, remainder dropped, next packet aligns
    clear_window();
    plan_packet(7, 4'b1111, 3, 3, 3, 3, 14);
    st_rst[9] = 1'b1;
    for (int c = 10; c < 20; c++) begin
      ex_v[c] = 4'b0000; ex_d[c] = 32'h0; ex_a[c] = 1'b0; ex_e[c] = 1'b0;
    end
    plan_packet(8, 4'b1111, 20, 21, 20, 22, 6);
    run_window(6, 3'd4);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check_val("scoreboard drained", sb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
